// File: rtl/demux_arbiter_ctrl.sv
// rtl/demux_arbiter_ctrl.sv - round-robin arbiter driving a downstream 1:4 demux
//
// Purpose: grants one of four requesters ownership of a 1:4 demux. The
// winner is picked round-robin. A grant ends on the winner's done, on the
// winner dropping its request, or by force after MAX_HOLD cycles. One dead
// (GAP) cycle always separates two grants.
//
// Ports:
//   input_clk    - system clock, rising edge
//   input_rst_n  - asynchronous active-low reset
//   input_req    - [3:0] level-sensitive request per requester
//   input_done   - [3:0] completion per requester (only the winner's bit counts)
//   out_sel      - [1:0] demux select code of the current/last winner
//   out_e        - demux data enable, high during a grant
//   out_grant    - [3:0] one-hot grant
//   out_busy     - high while a grant is active
//   out_timeout  - one-cycle pulse in the GAP that follows a forced release
module demux_arbiter_ctrl #(
  parameter int MAX_HOLD = 15
) (
  input  logic       input_clk,
  input  logic       input_rst_n,
  input  logic [3:0] input_req,
  input  logic [3:0] input_done,
  output logic [1:0] out_sel,
  output logic       out_e,
  output logic [3:0] out_grant,
  output logic       out_busy,
  output logic       out_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] winner;
  logic [1:0] last_granted;
  logic [3:0] hold_cnt;

  // Downstream demux wiring is not in requester order.
  function automatic logic [1:0] sel_code(input logic [1:0] idx);
    case (idx)
      2'd0:    sel_code = 2'b11;
      2'd1:    sel_code = 2'b01;
      2'd2:    sel_code = 2'b10;
      default: sel_code = 2'b00;
    endcase
  endfunction

  // Scan offsets from farthest to nearest so the nearest requester after
  // 'last' is the final assignment; offset 4 wraps back to 'last' itself,
  // giving it the lowest priority.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  logic [1:0] pick;
  logic       done_w;
  logic       drop_w;
  logic       hold_max;

  always_comb begin
    pick     = rr_pick(input_req, last_granted);
    done_w   = input_done[winner];
    drop_w   = ~input_req[winner];
    hold_max = (hold_cnt == 4'(MAX_HOLD - 1));
  end

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      state        <= IDLE;
      winner       <= 2'd0;
      last_granted <= 2'd3;
      hold_cnt     <= 4'd0;
      out_sel      <= 2'b00;
      out_e        <= 1'b0;
      out_grant    <= 4'b0000;
      out_busy     <= 1'b0;
      out_timeout  <= 1'b0;
    end else begin
      out_timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          // IDLE and GAP share the grant-start path; GAP has already
          // advanced last_granted so the search moves past the old winner.
          if (|input_req) begin
            state     <= GRANT;
            winner    <= pick;
            hold_cnt  <= 4'd0;
            out_sel   <= sel_code(pick);
            out_e     <= 1'b1;
            out_grant <= 4'(1) << pick;
            out_busy  <= 1'b1;
          end else begin
            state     <= IDLE;
            out_e     <= 1'b0;
            out_grant <= 4'b0000;
            out_busy  <= 1'b0;
          end
        end

        GRANT: begin
          if (done_w || drop_w || hold_max) begin
            state        <= GAP;
            last_granted <= winner;
            out_e        <= 1'b0;
            out_grant    <= 4'b0000;
            out_busy     <= 1'b0;
            // A natural release on the same edge as the hold limit wins.
            out_timeout  <= ~(done_w || drop_w);
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end

        default: begin
          state     <= IDLE;
          out_e     <= 1'b0;
          out_grant <= 4'b0000;
          out_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_arbiter_ctrl.sv
// tb/tb_demux_arbiter_ctrl.sv - scoreboard bench for demux_arbiter_ctrl
module tb_demux_arbiter_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [1:0] sel;
  logic       e;
  logic [3:0] grant;
  logic       busy;
  logic       tmo;

  demux_arbiter_ctrl #(.MAX_HOLD(15)) dut (
    .input_clk   (clk),
    .input_rst_n (rst_n),
    .input_req   (req),
    .input_done  (done),
    .out_sel     (sel),
    .out_e       (e),
    .out_grant   (grant),
    .out_busy    (busy),
    .out_timeout (tmo)
  );

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    int         len;
    logic       tmo;
  } ep_t;

  ep_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [3:0] g, input logic [1:0] s, input int len, input logic t);
    ep_t it;
    it.grant = g; it.sel = s; it.len = len; it.tmo = t;
    exp_q.push_back(it);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req_v, $time);
    end
  endtask

  function automatic logic [1:0] exp_sel(input logic [3:0] g);
    case (g)
      4'b0001: exp_sel = 2'b11;
      4'b0010: exp_sel = 2'b01;
      4'b0100: exp_sel = 2'b10;
      default: exp_sel = 2'b00;
    endcase
  endfunction

  // Monitor: per-cycle invariants plus grant-episode scoreboard.
  logic       in_ep = 1'b0;
  logic [3:0] cur_g;
  logic [1:0] cur_s;
  int         cur_len;

  always @(negedge clk) begin
    ep_t it;
    logic ended;
    ended = 1'b0;
    n_cmp++;
    if (!(grant == 4'b0 || $onehot(grant)) || (e !== |grant) || (busy !== e) ||
        (e && sel !== exp_sel(grant))) begin
      n_bad++;
      $display("FAIL invariant: e=%b grant=%b sel=%b busy=%b at %0t", e, grant, sel, busy, $time);
    end
    if (!in_ep && e) begin
      in_ep = 1'b1; cur_g = grant; cur_s = sel; cur_len = 1;
    end else if (in_ep && e) begin
      if (grant !== cur_g || sel !== cur_s) begin
        n_cmp++; n_bad++;
        $display("FAIL grant_stable: got %b/%b expected %b/%b at %0t", grant, sel, cur_g, cur_s, $time);
      end
      cur_len++;
    end else if (in_ep && !e) begin
      in_ep = 1'b0; ended = 1'b1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL episode: unexpected grant %b at %0t", cur_g, $time);
      end else begin
        it = exp_q.pop_front();
        if (cur_g !== it.grant || cur_s !== it.sel || cur_len != it.len || tmo !== it.tmo) begin
          n_bad++;
          $display("FAIL episode: got grant=%b sel=%b len=%0d tmo=%b expected grant=%b sel=%b len=%0d tmo=%b at %0t",
                   cur_g, cur_s, cur_len, tmo, it.grant, it.sel, it.len, it.tmo, $time);
        end
      end
    end
    if (!ended && tmo) begin
      n_cmp++; n_bad++;
      $display("FAIL stray_timeout: got 1 expected 0 at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 4'b0; done = 4'b0;
    #2;
    chk("rst_e",     {7'b0, e},     8'h00);
    chk("rst_grant", {4'b0, grant}, 8'h00);
    chk("rst_sel",   {6'b0, sel},   8'h00);
    chk("rst_busy",  {7'b0, busy},  8'h00);
    chk("rst_tmo",   {7'b0, tmo},   8'h00);

    // Full round robin with done after two grant cycles.
    push(4'b0001, 2'b11, 2, 1'b0);
    push(4'b0010, 2'b01, 2, 1'b0);
    push(4'b0100, 2'b10, 2, 1'b0);
    push(4'b1000, 2'b00, 2, 1'b0);
    push(4'b0001, 2'b11, 2, 1'b0);
    push(4'b0010, 2'b01, 1, 1'b0);
    req = 4'b1111;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 done = 4'(1) << (i % 4);
      @(posedge clk); #1 done = 4'b0;
      @(posedge clk);
    end
    #1 req = 4'b0;
    repeat (3) @(posedge clk);

    // Forced release after 15 cycles, then re-grant to requester 2.
    push(4'b0100, 2'b10, 15, 1'b1);
    push(4'b0100, 2'b10, 1, 1'b0);
    @(posedge clk); #1 req = 4'b0100;
    repeat (17) @(posedge clk);
    #1 req = 4'b0;
    repeat (3) @(posedge clk);

    // Done on the same edge as the hold limit: no timeout.
    push(4'b0010, 2'b01, 15, 1'b0);
    @(posedge clk); #1 req = 4'b0010;
    repeat (15) @(posedge clk);
    #1 done = 4'b0010;
    @(posedge clk); #1 done = 4'b0; req = 4'b0;
    repeat (3) @(posedge clk);

    // Non-winner done/req activity ignored; then grant 3 cut by reset.
    push(4'b0001, 2'b11, 5, 1'b0);
    push(4'b1000, 2'b00, 1, 1'b0);
    @(posedge clk); #1 req = 4'b0001;
    @(posedge clk);
    @(posedge clk); #1 done = 4'b0100; req = 4'b1001;
    @(posedge clk); #1 done = 4'b0000; req = 4'b0001;
    @(posedge clk); #1 req = 4'b1001;
    @(posedge clk); #1 req = 4'b1000;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("async_e",     {7'b0, e},     8'h00);
    chk("async_grant", {4'b0, grant}, 8'h00);
    chk("async_sel",   {6'b0, sel},   8'h00);
    chk("async_tmo",   {7'b0, tmo},   8'h00);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    push(4'b1000, 2'b00, 1, 1'b0);
    @(posedge clk); #1 req = 4'b0;
    repeat (3) @(posedge clk);

    // Two requesters alternate: 0, 2, 0.
    push(4'b0001, 2'b11, 1, 1'b0);
    push(4'b0100, 2'b10, 1, 1'b0);
    push(4'b0001, 2'b11, 1, 1'b0);
    @(posedge clk); #1 req = 4'b0101;
    @(posedge clk); #1 done = 4'b0001;
    @(posedge clk); #1 done = 4'b0000;
    @(posedge clk); #1 done = 4'b0100;
    @(posedge clk); #1 done = 4'b0000;
    @(posedge clk); #1 req = 4'b0;
    repeat (4) @(posedge clk);

    #1;
    chk("queue_empty", 8'(exp_q.size()), 8'h00);
    chk("no_open_ep",  {7'b0, in_ep},     8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
